// File: rtl/booth_mul_pkg.sv
// rtl/booth_mul_pkg.sv - shared constants for the Booth multiplier arbiter
package booth_mul_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int MUL_START_TO_P = 5;
    // BUSY begins one cycle after start, so its last count lands on start+5
    localparam logic [2:0] BUSY_LAST = 3'(MUL_START_TO_P - 1);

endpackage

// File: rtl/booth_mul_arbiter_rr.sv
// rtl/booth_mul_arbiter_rr.sv - combinational round-robin picker
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic           found;
    logic [IDW-1:0] cand;

    // Scan from the requester after the previous winner, wrapping at N
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(last) + 1 + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin front end sharing one Booth multiplier
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    input  logic [OPW*N-1:0]   req_a,
    input  logic [OPW*N-1:0]   req_b,
    output logic [N-1:0]       req_ready,
    output logic               resp_valid,
    output logic [IDW-1:0]     resp_id,
    output logic [PW-1:0]      resp_p,
    output logic               busy,
    output logic               mul_rst_n,
    output logic               mul_start,
    output logic [OPW-1:0]     mul_a,
    output logic [OPW-1:0]     mul_b,
    input  logic [PW-1:0]      mul_p
);

    logic [1:0]     state;
    logic [2:0]     cnt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] cur_id;
    logic [N-1:0]   arb_req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] gidx;
    logic           accept;
    logic [OPW-1:0] sel_a;
    logic [OPW-1:0] sel_b;

    // Grants only from IDLE and never while reset is held
    assign arb_req = (state == ST_IDLE && !rst) ? req_valid : '0;

    rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
        .req   (arb_req),
        .last  (last),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready  = grant;
    assign accept     = |grant;
    assign busy       = (state != ST_IDLE) || accept;
    assign mul_start  = (state == ST_ISSUE);
    assign resp_valid = (state == ST_RESP);
    assign mul_rst_n  = ~rst;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*OPW +: OPW];
                sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last    <= IDW'(N - 1);
            cur_id  <= '0;
            resp_id <= '0;
            resp_p  <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mul_a  <= sel_a;
                        mul_b  <= sel_b;
                        cur_id <= gidx;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (cnt == BUSY_LAST) begin
                        resp_p  <= mul_p;
                        resp_id <= cur_id;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    last  <= cur_id;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;
    import booth_mul_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [4*N-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic [IDW-1:0]   resp_id;
    logic [7:0]       resp_p;
    logic             busy, mul_rst_n, mul_start;
    logic [3:0]       mul_a, mul_b;
    logic [7:0]       mul_p;

    booth_mul_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_p(resp_p), .busy(busy), .mul_rst_n(mul_rst_n), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] smul(input logic signed [3:0] a, input logic signed [3:0] b);
        logic signed [7:0] r;
        r = a * b;
        return r;
    endfunction

    // Multiplier stand-in: product visible start+5 and start+6, idle again at start+7
    logic [3:0] m_a, m_b;
    int         m_age = 0;
    logic       m_act = 1'b0;
    always @(posedge clk) begin
        if (!mul_rst_n) begin
            m_act <= 1'b0;
            m_age <= 0;
        end else if (m_act) begin
            if (m_age == 6) m_act <= 1'b0;
            m_age <= m_age + 1;
        end else if (mul_start) begin
            m_act <= 1'b1;
            m_age <= 1;
            m_a   <= mul_a;
            m_b   <= mul_b;
        end
    end
    assign mul_p = (m_act && (m_age == 5 || m_age == 6)) ? smul(m_a, m_b) : 8'h00;

    typedef struct {
        int         id;
        logic [7:0] p;
        int         t;
    } exp_t;
    exp_t sb[$];
    int   last_start = -100;

    // Scoreboard: push on accept, pop on response
    always @(negedge clk) begin
        if (rst) begin
            last_start = -100;
        end else begin
            if (|req_ready) begin
                exp_t e;
                chk("ready_onehot", $countones(req_ready), 1);
                e.id = 0;
                e.p  = 8'h00;
                for (int i = 0; i < N; i++)
                    if (req_ready[i]) begin
                        e.id = i;
                        e.p  = smul(req_a[i*4 +: 4], req_b[i*4 +: 4]);
                    end
                e.t = cyc;
                sb.push_back(e);
            end
            if (mul_start) begin
                chk("start_gap_ge8", 32'(cyc - last_start >= 8), 1);
                last_start = cyc;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", 32'(resp_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id", 32'(resp_id), e.id);
                    chk("sb_p", 32'(resp_p), 32'(e.p));
                    chk("sb_latency", cyc - e.t, 7);
                end
            end
        end
    end

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;
    vec_t vecs[6];

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},  32'(req_ready), 0);
        chk({tag, "_rvalid"}, 32'(resp_valid), 0);
        chk({tag, "_rid"},    32'(resp_id), 0);
        chk({tag, "_rp"},     32'(resp_p), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_start"},  32'(mul_start), 0);
        chk({tag, "_mula"},   32'(mul_a), 0);
        chk({tag, "_mulb"},   32'(mul_b), 0);
        chk({tag, "_mulrstn"}, 32'(mul_rst_n), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
        req_valid[id] = 1'b1;
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
    endtask

    task automatic wait_grant(input int limit, output int id, output int t);
        id = -1;
        t  = cyc;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (|req_ready) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
                t = cyc;
                return;
            end
        end
        chk("grant_timeout", 32'(|req_ready), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int gid, t, n;
        @(posedge clk); #1;
        req_valid = '0;
        set_req(v.id, v.a, v.b);
        wait_grant(20, gid, t);
        chk("vec_grant", gid, v.id);
        chk("vec_busy_at_accept", 32'(busy), 1);
        chk("vec_nostart_at_accept", 32'(mul_start), 0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("vec_start_t1", 32'(mul_start), 1);
        for (n = 2; n < 20; n++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        chk("vec_latency", n, 7);
        chk("vec_p", 32'(resp_p), 32'(v.p));
        chk("vec_id", 32'(resp_id), v.id);
        @(negedge clk);
        chk("vec_idle_busy", 32'(busy), 0);
        chk("vec_p_hold", 32'(resp_p), 32'(v.p));
    endtask

    initial begin
        int gid, t, prev, seen1, seen_resp;
        int order[5] = '{0, 1, 2, 3, 0};

        vecs[0] = '{2, 4'd3, 4'd5, 8'h0F};
        vecs[1] = '{0, 4'h8, 4'h8, 8'h40};
        vecs[2] = '{1, 4'h7, 4'h8, 8'hC8};
        vecs[3] = '{3, 4'hF, 4'h1, 8'hFF};
        vecs[4] = '{2, 4'h0, 4'h8, 8'h00};
        vecs[5] = '{1, 4'hD, 4'h4, 8'hF4};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Four requesters held: grants rotate 0,1,2,3,0 eight cycles apart
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 4'(i - 2));
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(20, gid, t);
            chk("rr_order", gid, order[g]);
            if (g > 0) chk("rr_gap", t - prev, 8);
            prev = t;
            @(posedge clk); #1;
            if (g == 4) req_valid = '0;
        end
        repeat (10) @(posedge clk);

        // Requester 1 withdraws while 0 is being served
        do_reset();
        @(posedge clk); #1;
        set_req(0, 4'd2, 4'd2);
        set_req(1, 4'd3, 4'd3);
        wait_grant(20, gid, t);
        chk("drop_first", gid, 0);
        @(posedge clk); #1;
        req_valid = '0;
        set_req(2, 4'hA, 4'd3);
        seen1 = 0;
        gid = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[1]) seen1 = 1;
            if (|req_ready) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
                break;
            end
        end
        chk("drop_no_ready1", seen1, 0);
        chk("drop_next_grant", gid, 2);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (10) @(posedge clk);

        // Reset during BUSY aborts the operation
        @(posedge clk); #1;
        set_req(1, 4'hD, 4'd4);
        wait_grant(20, gid, t);
        chk("abort_grant", gid, 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mulrstn", 32'(mul_rst_n), 0);
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        seen_resp = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1;
        end
        chk("abort_no_resp", seen_resp, 0);
        run_vec(vecs[5]);

        // Back-to-back from one requester
        @(posedge clk); #1;
        set_req(3, 4'd5, 4'h9);
        prev = 0;
        for (int g = 0; g < 3; g++) begin
            wait_grant(20, gid, t);
            chk("b2b_id", gid, 3);
            if (g > 0) chk("b2b_gap", t - prev, 8);
            prev = t;
            @(posedge clk); #1;
            if (g == 2) req_valid = '0;
        end
        repeat (12) @(posedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin front end that shares one 4-bit signed Booth multiplier among N requesters. Requesters use a valid/ready handshake. The block does four things in turn: picks a winner, registers its operands, issues a one-cycle start to the multiplier, and captures the product at the fixed multiplier latency. It then returns the product with the winner's ID. It sits between the client logic and the multiplier instance, and owns the multiplier's start, operand and reset pins.

## Interface
- N, 4, number of requesters (2..8)
- IDW, $clog2(N), width of requester ID
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester request
- req_a  in  4N  packed signed operand a; slice i = bits [4i+3:4i]
- req_b  in  4N  packed signed operand b; same packing
- req_ready  out  N  one-hot accept strobe
- resp_valid  out  1  one-cycle product strobe
- resp_id  out  IDW  requester index for resp_p
- resp_p  out  8  signed product a*b
- busy  out  1  high from accept through response
- mul_rst_n  out  1  multiplier reset, = ~rst (combinational)
- mul_start  out  1  multiplier start pulse
- mul_a, mul_b  out  4 each  multiplier operands
- mul_p  in  8  multiplier product

## Operation
- Multiplier contract:
  - Operands are sampled on the cycle mul_start=1 while the multiplier is idle.
  - mul_p is valid 5 and 6 cycles after the start cycle and 0 otherwise.
  - The multiplier is idle again 7 cycles after start.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid is set, the round-robin pick selects winner w.
  - req_ready[w]=1 combinationally, same cycle.
  - Slices a[w] and b[w] are registered into mul_a and mul_b, and w into cur_id.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE: mul_start=1 for exactly one cycle; clear cnt; go to BUSY.
- BUSY:
  - cnt increments 0..4.
  - At cnt==4, register mul_p into resp_p and go to RESP.
- RESP: resp_valid=1 and resp_id=cur_id for one cycle; update last=cur_id; go to IDLE.
- Round-robin:
  - Priority starts at (last+1) mod N and wraps.
  - last resets to N-1, so requester 0 wins first.
  - A continuously requesting client waits at most N-1 grants.
- req_ready is only ever asserted in IDLE, and at most one bit per cycle.
- Requester rules:
  - Hold operands stable while req_valid=1 with no ready.
  - Dropping req_valid before ready is legal; no grant is issued.
- resp_valid has no back-pressure; the consumer must accept it.
- Arithmetic: two's complement throughout. The full range -8..7 squared is exact in 8 bits, including (-8)*(-8)=+64.
- Reset:
  - rst asserted in any state returns to IDLE next edge and discards the in-flight operation; no response is produced.
  - mul_rst_n is low during rst, so the multiplier resets together with this block.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_p=0, busy=0, mul_start=0, mul_a=0, mul_b=0, cnt=0, last=N-1, state=IDLE.
- Accept at cycle t:
  - ISSUE (mul_start=1) at t+1.
  - BUSY at t+2..t+6; mul_p is sampled at t+6 (start+5).
  - resp_valid at t+7.
  - IDLE at t+8, earliest next accept; its mul_start at t+9, when the multiplier is idle.
- Latency is 7 cycles accept→response. Throughput is one product per 8 cycles.
- busy is 1 for cycles t..t+7.
- resp_p holds its value until the next capture. resp_id holds cur_id after RESP.

## Structure
- Package booth_mul_pkg:
  - State encoding (IDLE=0, ISSUE=1, BUSY=2, RESP=3).
  - MUL_START_TO_P=5, BUSY_LAST=4.
  - Operand width 4 and product width 8.
- Sub-module rr_arbiter (N parameter): inputs req and last, output one-hot grant plus encoded index. Purely combinational.
- Top: FSM, counter, operand/ID/result registers.

## Test plan
- Reset then a single request, req_valid[2]=1 with a=3, b=5:
  - req_ready[2] at t.
  - mul_start at t+1.
  - resp_valid at t+7 with resp_id=2 and resp_p=0x0F.
- Signed corners:
  - (-8)*(-8) → 0x40.
  - 7*(-8) → 0xC8.
  - (-1)*1 → 0xFF.
  - 0*(-8) → 0x00.
- All four requesters held valid for 5 operations:
  - Grant order 0,1,2,3,0.
  - Accepts 8 cycles apart.
  - Each resp_id matches its grant.
- req_valid[1] dropped while ISSUE/BUSY for another requester: no req_ready[1], and the next grant skips it.
- rst pulsed at t+4 during BUSY:
  - No resp_valid follows.
  - All outputs are at reset values and mul_rst_n=0 during rst.
  - A new request completes with the correct product.
- Back-to-back requests from one requester: mul_start never fires within 7 cycles of the previous mul_start.
